// File: rtl/cbfp_pkg.sv
// cbfp_pkg: constants and the shift-and-saturate helper shared by the CBFP normalizer and denormalizer
package cbfp_pkg;
  localparam int EXP_W = 5;
  localparam int TRUNC_VALUE = 12;
  localparam int BEATS_PER_BLK = 4;
  localparam int EXP_DEPTH = 8;
  localparam logic signed [EXP_W:0] TRUNC_S = (EXP_W + 1)'(TRUNC_VALUE);
  typedef struct packed {
    logic sat;
    logic signed [31:0] v;
  } shsat_t;
  // x is already sign-extended; s>0 shifts right (floor), s<0 shifts left and may clamp to out_w
  function automatic shsat_t shift_sat(input logic signed [31:0] x, input logic signed [EXP_W:0] s, input int out_w);
    logic signed [31:0] y, hi, lo;
    shsat_t r;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    y = s[EXP_W] ? x <<< (-s) : x >>> s;
    r.sat = y > hi || y < lo;
    r.v = y > hi ? hi : y < lo ? lo : y;
    return r;
  endfunction
endpackage

// File: rtl/cbfp_exp_fifo.sv
// cbfp_exp_fifo: synchronous exponent FIFO with registered occupancy count
//   push_i/din_i : write request and data (dropped when full unless a pop happens the same cycle)
//   pop_i/dout_o : read request and head-of-queue data (dout_o is the current head)
//   full_o/empty_o : occupancy flags derived from the registered count
module cbfp_exp_fifo import cbfp_pkg::*; #(
  parameter int W = EXP_W,
  parameter int DEPTH = EXP_DEPTH
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW + 1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  // when full, a same-cycle pop frees the slot the push writes into
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
endmodule

// File: rtl/cbfp_denorm_module.sv
// cbfp_denorm_module: pairs 4-beat blocks with their block exponent, undoes CBFP normalization, saturates
//   idx_valid/idx_in      : block exponent from the normalizer, queued in a small FIFO
//   valid_in/data_*_in    : 16-lane normalized complex beats (IN_W signed per lane)
//   valid_out/data_*_out  : denormalized beats, 2 cycles after input; hold when valid_out=0
//   sat_out               : some lane of this output beat clamped
//   exp_overflow/underflow: registered pulses for a dropped exponent / a block started without one
module cbfp_denorm_module import cbfp_pkg::*; #(
  parameter int IN_W = 11,
  parameter int OUT_W = 16,
  parameter int NCHAN = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   idx_valid,
  input  logic [EXP_W-1:0]       idx_in,
  input  logic                   valid_in,
  input  logic [NCHAN*IN_W-1:0]  data_re_in,
  input  logic [NCHAN*IN_W-1:0]  data_im_in,
  output logic [NCHAN*OUT_W-1:0] data_re_out,
  output logic [NCHAN*OUT_W-1:0] data_im_out,
  output logic                   valid_out,
  output logic                   sat_out,
  output logic                   exp_overflow,
  output logic                   exp_underflow
);
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
  localparam int CW = $clog2(BEATS_PER_BLK);
  logic [0:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] exp_q, exp_d, fifo_dout, s1_exp_q;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop, start, ovf_d, unf_d, ovf_q, unf_q;
  logic s1_v_q, v2_q, sat_q, sat_d;
  logic [NCHAN*IN_W-1:0] s1_re_q, s1_im_q;
  logic [NCHAN*OUT_W-1:0] re_q, im_q, re_d, im_d;
  logic signed [EXP_W:0] s;
  shsat_t rr, ri;
  cbfp_exp_fifo #(.W(EXP_W), .DEPTH(EXP_DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push_i(fifo_push), .pop_i(fifo_pop), .din_i(idx_in),
    .dout_o(fifo_dout), .full_o(fifo_full), .empty_o(fifo_empty)
  );
  always_comb begin
    start = valid_in && state_q == IDLE;
    fifo_pop = start && !fifo_empty;
    // a coincident idx on an empty FIFO is consumed directly by the starting block
    fifo_push = idx_valid && !(start && fifo_empty) && (!fifo_full || fifo_pop);
    ovf_d = idx_valid && fifo_full && !fifo_pop;
    unf_d = start && fifo_empty && !idx_valid;
    exp_d = !start ? exp_q : !fifo_empty ? fifo_dout : idx_valid ? idx_in : EXP_W'(TRUNC_VALUE);
    cnt_d = !valid_in ? cnt_q : cnt_q == CW'(BEATS_PER_BLK - 1) ? '0 : cnt_q + 1'b1;
    state_d = cnt_d == '0 ? IDLE : ACTIVE;
  end
  always_comb begin
    re_d = re_q;
    im_d = im_q;
    sat_d = sat_q;
    rr = '0;
    ri = '0;
    s = $signed({1'b0, s1_exp_q}) - TRUNC_S;
    if (s1_v_q) begin
      sat_d = 1'b0;
      for (int k = 0; k < NCHAN; k++) begin
        rr = shift_sat(32'($signed(s1_re_q[k*IN_W +: IN_W])), s, OUT_W);
        ri = shift_sat(32'($signed(s1_im_q[k*IN_W +: IN_W])), s, OUT_W);
        re_d[k*OUT_W +: OUT_W] = rr.v[OUT_W-1:0];
        im_d[k*OUT_W +: OUT_W] = ri.v[OUT_W-1:0];
        sat_d = sat_d | rr.sat | ri.sat;
      end
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      exp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      s1_v_q <= 1'b0;
      s1_re_q <= '0;
      s1_im_q <= '0;
      s1_exp_q <= '0;
      v2_q <= 1'b0;
      sat_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      exp_q <= exp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      s1_v_q <= valid_in;
      if (valid_in) begin
        s1_re_q <= data_re_in;
        s1_im_q <= data_im_in;
        s1_exp_q <= exp_d;
      end
      v2_q <= s1_v_q;
      sat_q <= sat_d;
      re_q <= re_d;
      im_q <= im_d;
    end
  assign data_re_out = re_q;
  assign data_im_out = im_q;
  assign valid_out = v2_q;
  assign sat_out = sat_q;
  assign exp_overflow = ovf_q;
  assign exp_underflow = unf_q;
endmodule

// File: doc/cbfp_denorm_module.md
Name: cbfp_denorm_module

Overview:
Inverse of the CBFP0 normalizer; sits at the FFT output, after the last butterfly stage and before the output formatter.
Accepts 16-lane normalized complex beats (IN_W) in blocks of 4 beats (64 samples), each block carrying one block exponent (idx).
Queues exponents in a small FIFO, pairs each block with its exponent, undoes the normalization shift, and saturates to OUT_W.

Parameters:
IN_W, 11, normalized input sample width (signed, <5.6>)
OUT_W, 16, denormalized output sample width (signed)
NCHAN, 16, lanes per beat
BEATS_PER_BLK, 4, beats sharing one exponent
EXP_W, 5, exponent width
TRUNC_VALUE, 12, exponent value meaning "no shift applied"
EXP_DEPTH, 8, exponent FIFO depth (power of 2)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
idx_valid  in  1  idx_in valid this cycle (one pulse per block)
idx_in  in  EXP_W  block exponent produced by normalizer
valid_in  in  1  data beat valid
data_re_in  in  IN_W x NCHAN  signed real lanes
data_im_in  in  IN_W x NCHAN  signed imag lanes
data_re_out  out  OUT_W x NCHAN  denormalized real lanes
data_im_out  out  OUT_W x NCHAN  denormalized imag lanes
valid_out  out  1  output beat valid
sat_out  out  1  any lane saturated in this output beat
exp_overflow  out  1  pulse: idx_in dropped, FIFO full
exp_underflow  out  1  pulse: block started with no exponent available

Behaviour:
- Reset (async, rstn low): all outputs 0, FIFO empty, beat_cnt=0, FSM=IDLE. Reset mid-block discards the partial block and all queued exponents.
- FIFO push: idx_valid && !full. If idx_valid && full && no pop this cycle -> drop, exp_overflow=1 for 1 cycle. Push+pop in the same cycle when full -> both accepted.
- FSM IDLE (beat_cnt==0): a valid_in beat starts a block.
  - Exponent source: FIFO head if non-empty (pop).
  - Else, if idx_valid is high the same cycle: bypass idx_in, no push.
  - Else: exp_underflow=1 for 1 cycle, use exponent TRUNC_VALUE (shift 0).
  - Go to ACTIVE, beat_cnt=1.
- ACTIVE: each valid_in beat uses the latched exponent and increments beat_cnt. At beat_cnt==BEATS_PER_BLK-1, the beat ends the block: beat_cnt wraps to 0, FSM -> IDLE. Gaps in valid_in hold state; no timeout.
- Shift: s = idx - TRUNC_VALUE (signed, EXP_W+1 bits).
  - s>0: out = sext(in) >>> s (arithmetic, floor).
  - s<0: out = sext(in) <<< -s.
  - s=0: sign-extend only.
- Saturation: left-shift results exceeding OUT_W clamp to +2^(OUT_W-1)-1 / -2^(OUT_W-1); sat_out = OR over all 32 lane results.
- Pipeline, latency 2:
  - Stage 1 registers the data beat and the resolved exponent.
  - Stage 2 registers shifted and saturated lanes, sat_out, and valid_out.
  - valid_out equals valid_in delayed exactly 2 cycles. Outputs hold their last value when valid_out=0.
- exp_overflow and exp_underflow are registered, 1 cycle after the causing event.

Decomposition:
- cbfp_pkg: EXP_W, TRUNC_VALUE, BEATS_PER_BLK, and a shift-and-saturate function, shared with the normalizer.
- Sub-module cbfp_exp_fifo: sync FIFO with full/empty and registered count. The FSM, beat counter and lane datapath stay in the top module.

Test Plan:
- Push idx=12, 4 beats of all lanes re=100, im=-100 -> 2 cycles after each beat: re=100, im=-100, sat_out=0, valid_out for exactly 4 cycles.
- Push idx=15, beats re=64, im=-7 -> re=8, im=-1 (floor); idx=9, re=5 -> re=40.
- idx=0 (s=-12), re=1023 with OUT_W=16 -> re=32767, sat_out=1; re=-1024 -> -32768.
- Back-to-back blocks with idx 12, 14, 10 pushed up front, 12 contiguous beats -> correct exponent per 4-beat group, FIFO empty at end; idx_valid coincident with first beat on empty FIFO -> bypass used, no underflow.
- 9 idx pushes with no data -> exp_overflow on the 9th; data beat on empty FIFO without idx_valid -> exp_underflow=1, shift 0.
- Assert rstn low after beat 2 of a block -> outputs 0; after release, the next beat starts a new block with a fresh exponent.
